// File: rtl/vector_result_serializer_if.sv
// vector_result_serializer_if: port bundle between the divider-facing capture side and the element stream side
//   in_valid/in_data : one-cycle vector capture pulse and the N-element vector
//   out_valid/out_ready/out_data/out_index/out_last : element stream handshake
//   count/full/overflow : buffer occupancy and sticky drop flag
interface vector_result_serializer_if #(
  parameter int BITS  = 16,
  parameter int N     = 3,
  parameter int DEPTH = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic                     in_valid;
  logic [N-1:0][BITS-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [BITS-1:0]          out_data;
  logic [IW-1:0]            out_index;
  logic                     out_last;
  logic [CW-1:0]            count;
  logic                     full;
  logic                     overflow;
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_index, out_last, count, full, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_index, out_last, count, full, overflow
  );
endinterface

// File: rtl/vector_result_serializer.sv
// vector_result_serializer: buffers divider result vectors and streams them out one element per handshake
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : slave side of vector_result_serializer_if (capture port, element stream, count/full/overflow)
module vector_result_serializer #(
  parameter int BITS  = 16,
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  vector_result_serializer_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [N-1:0][BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   hs, pop, wr;
  always_comb begin
    hs    = (cnt_q != '0) && bus.out_ready;
    pop   = hs && (idx_q == IW'(N - 1));
    // a full buffer can still take a vector when the head leaves in the same cycle
    wr    = bus.in_valid && ((cnt_q != CW'(DEPTH)) || pop);
    idx_d = hs ? (pop ? '0 : idx_q + IW'(1)) : idx_q;
    rd_d  = pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
    wr_d  = wr ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
    cnt_d = cnt_q + CW'(wr) - CW'(pop);
    ovf_d = ovf_q || (bus.in_valid && !wr);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr) mem_q[wr_q] <= bus.in_data;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data  = mem_q[rd_q][idx_q];
  assign bus.out_index = idx_q;
  assign bus.out_last  = idx_q == IW'(N - 1);
  assign bus.count     = cnt_q;
  assign bus.full      = cnt_q == CW'(DEPTH);
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_vector_result_serializer.sv
// tb_vector_result_serializer: scoreboard bench for vector_result_serializer
module tb_vector_result_serializer;
  localparam int BITS = 16, N = 3, DEPTH = 4;
  typedef logic [N-1:0][BITS-1:0] vec_t;
  typedef logic [BITS+2:0] elem_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  vector_result_serializer_if #(.BITS(BITS), .N(N), .DEPTH(DEPTH)) bus ();
  vector_result_serializer #(.BITS(BITS), .N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  elem_t q[$];
  int m_cnt, m_idx, n_tests, n_fail;
  logic m_ovf;
  function automatic vec_t mk(input int e0);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = BITS'(e0 + k * 256);
    return v;
  endfunction
  task automatic do_reset();
    rstn = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = mk(16'h7777);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    m_cnt = 0;
    m_idx = 0;
    m_ovf = 1'b0;
  endtask
  task automatic step(input logic v, input vec_t d, input logic r, output logic hs, output elem_t got, output elem_t exp);
    logic pop, acc;
    hs = (m_cnt != 0) && r;
    got = {bus.out_data, bus.out_index, bus.out_last};
    exp = '0;
    pop = hs && (m_idx == N - 1);
    if (hs) begin
      if (q.size() != 0) exp = q.pop_front();
      m_idx = pop ? 0 : m_idx + 1;
    end
    acc = v && ((m_cnt < DEPTH) || pop);
    if (acc) for (int k = 0; k < N; k++) q.push_back({d[k], 2'(k), k == N - 1});
    m_cnt = m_cnt + int'(acc) - int'(pop);
    m_ovf = m_ovf || (v && !acc);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({bus.out_valid, bus.out_last, bus.full, bus.overflow} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags valid/last/full/ovf got=%b exp=0000", {bus.out_valid, bus.out_last, bus.full, bus.overflow});
    end
    n_tests++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    n_tests++;
    if (bus.out_index !== '0) begin n_fail++; $display("FAIL reset_index got=%0d exp=0", bus.out_index); end
    n_tests++;
    if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
  endtask
  task automatic test_single();
    logic hs;
    elem_t got, exp;
    vec_t ev;
    ev = {16'h4200, 16'h4000, 16'h3C00};
    do_reset();
    step(1'b1, ev, 1'b1, hs, got, exp);
    n_tests++;
    if (bus.count !== 3'd1) begin n_fail++; $display("FAIL single_count1 got=%0d exp=1", bus.count); end
    for (int k = 0; k < N; k++) begin
      step(1'b0, '0, 1'b1, hs, got, exp);
      n_tests++;
      if (!hs || got !== exp || got !== {ev[k], 2'(k), k == N - 1}) begin
        n_fail++;
        $display("FAIL single_elem%0d got=%h exp=%h", k, got, {ev[k], 2'(k), k == N - 1});
      end
    end
    n_tests++;
    if (bus.count !== '0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end count/ovf got=%0d/%b exp=0/0", bus.count, bus.overflow);
    end
  endtask
  task automatic test_backpressure();
    logic hs;
    elem_t got, exp;
    do_reset();
    step(1'b1, {16'h4200, 16'h4000, 16'h3C00}, 1'b0, hs, got, exp);
    for (int s = 0; s < 5; s++) begin
      step(1'b0, '0, 1'b0, hs, got, exp);
      n_tests++;
      if (got !== {16'h3C00, 2'd0, 1'b0} || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall%0d got=%h exp=%h", s, got, {16'h3C00, 2'd0, 1'b0});
      end
    end
    for (int k = 0; k < N; k++) begin
      step(1'b0, '0, 1'b1, hs, got, exp);
      n_tests++;
      if (!hs || got !== exp) begin n_fail++; $display("FAIL bp_elem%0d got=%h exp=%h", k, got, exp); end
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
  endtask
  task automatic test_overflow();
    logic hs;
    elem_t got, exp;
    int e0s[$];
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, mk(i), 1'b0, hs, got, exp);
    n_tests++;
    if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state count/full/ovf got=%0d/%b/%b exp=4/1/1", bus.count, bus.full, bus.overflow);
    end
    for (int s = 0; s < 4 * N; s++) begin
      step(1'b0, '0, 1'b1, hs, got, exp);
      n_tests++;
      if (!hs || got !== exp) begin n_fail++; $display("FAIL ovf_drain%0d got=%h exp=%h", s, got, exp); end
      if (got[2:1] == 2'd0) e0s.push_back(int'(got[BITS+2:3]));
    end
    n_tests++;
    if (e0s.size() != 4 || e0s[0] != 1 || e0s[3] != 4 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_order vectors=%0d first=%0d last=%0d exp 4 vectors 1..4", e0s.size(), e0s[0], e0s[e0s.size() - 1]);
    end
  endtask
  task automatic test_simul();
    logic hs;
    elem_t got, exp;
    int last_e0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk(5 + i), 1'b0, hs, got, exp);
    for (int s = 0; s < 2; s++) begin
      step(1'b0, '0, 1'b1, hs, got, exp);
      n_tests++;
      if (!hs || got !== exp) begin n_fail++; $display("FAIL simul_pre%0d got=%h exp=%h", s, got, exp); end
    end
    step(1'b1, mk(9), 1'b1, hs, got, exp);
    n_tests++;
    if (!hs || got !== exp || got[0] !== 1'b1) begin n_fail++; $display("FAIL simul_pop got=%h exp=%h", got, exp); end
    n_tests++;
    if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_state count/ovf got=%0d/%b exp=4/0", bus.count, bus.overflow);
    end
    last_e0 = -1;
    for (int s = 0; s < 4 * N; s++) begin
      step(1'b0, '0, 1'b1, hs, got, exp);
      n_tests++;
      if (!hs || got !== exp) begin n_fail++; $display("FAIL simul_drain%0d got=%h exp=%h", s, got, exp); end
      if (got[2:1] == 2'd0) last_e0 = int'(got[BITS+2:3]);
    end
    n_tests++;
    if (last_e0 != 9) begin n_fail++; $display("FAIL simul_last got=%0d exp=9", last_e0); end
  endtask
  task automatic test_wrap();
    logic hs;
    elem_t got, exp;
    int nhs;
    do_reset();
    nhs = 0;
    for (int j = 0; j < 33; j++) begin
      step(j % 3 == 0 && j < 30, mk(20 + j / 3), 1'b1, hs, got, exp);
      if (hs) begin
        nhs++;
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_elem%0d got=%h exp=%h", nhs, got, exp); end
      end
    end
    n_tests++;
    if (nhs != 30 || bus.overflow !== 1'b0 || bus.count !== '0) begin
      n_fail++;
      $display("FAIL wrap_end hs/ovf/count got=%0d/%b/%0d exp=30/0/0", nhs, bus.overflow, bus.count);
    end
  endtask
  task automatic test_reset_mid();
    logic hs;
    elem_t got, exp;
    do_reset();
    step(1'b1, mk(16'h40), 1'b1, hs, got, exp);
    step(1'b0, '0, 1'b1, hs, got, exp);
    step(1'b0, '0, 1'b1, hs, got, exp);
    do_reset();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.count !== '0 || bus.out_data !== '0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst valid/count/data/ovf got=%b/%0d/%h/%b exp=0/0/0/0", bus.out_valid, bus.count, bus.out_data, bus.overflow);
    end
    step(1'b1, mk(16'h50), 1'b1, hs, got, exp);
    step(1'b0, '0, 1'b1, hs, got, exp);
    n_tests++;
    if (!hs || got !== exp || got[2:1] !== 2'd0) begin n_fail++; $display("FAIL midrst_new got=%h exp=%h", got, exp); end
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_result_serializer.md
# vector_result_serializer

Downstream stage for the vector divider: captures each N-element result vector on the divider's single-cycle `out_valid` pulse, buffers up to DEPTH vectors, and streams them out one element per handshake on a valid/ready port. The divider has no backpressure, so this block absorbs bursts and flags any vector it has to drop. Elements pass through unmodified; the block does no arithmetic on data.

## Interface
- `BITS`, 16, element width; matches the divider's `BITS`.
- `N`, 3, elements per vector, ≥1.
- `DEPTH`, 4, vectors buffered, ≥1; need not be a power of two.
- `IW` (localparam): `max(1, $clog2(N))`.
- `CW` (localparam): `$clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  one-cycle pulse; `in_data` is valid this cycle. Wired to the divider's `out_valid`.
- `in_data[N]`  in  BITS each  result vector (divider `c`).
- `out_valid`  out  1  head element available.
- `out_ready`  in  1  consumer accepts the element.
- `out_data`  out  BITS  current element of the head vector.
- `out_index`  out  IW  element position within the vector, 0..N-1.
- `out_last`  out  1  high when `out_index == N-1`.
- `count`  out  CW  vectors stored, 0..DEPTH, including a partially sent head.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; a vector was dropped.

## Operation
- **Storage**
  - Circular buffer of DEPTH entries, each N×BITS.
  - Write pointer and read pointer wrap from DEPTH-1 to 0, with explicit wrap logic (not power-of-two masking).
  - Registered `count`.
- **Element counter**
  - `idx` (IW bits) selects the element of the head entry.
  - `out_data = mem[rd_ptr][idx]`, `out_index = idx`.
  - `out_valid = (count != 0)`.
- **Handshake**
  - A handshake is `out_valid && out_ready`.
  - On a handshake with `idx < N-1`: `idx` increments.
  - On a handshake with `idx == N-1` (the pop): `idx` returns to 0, `rd_ptr` advances, and the entry is freed.
- **Accept rule**
  - A vector is written if `in_valid` is high and either `count < DEPTH` or a pop occurs in the same cycle.
  - On write: all N elements are captured together into `mem[wr_ptr]`, then `wr_ptr` advances.
- **Count update**
  - Write without pop: +1.
  - Pop without write: −1.
  - Write and pop in the same cycle: unchanged.
- **Drop**
  - If `in_valid` is high, `count == DEPTH`, and there is no pop this cycle, the vector is discarded.
  - `overflow` is set and stays high until reset.
  - No other state changes on a drop.
- **Stability**
  - While `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable.
  - A write never alters the head entry while `count > 0`.
- **N = 1**
  - `idx` is always 0, `out_last` is always 1, and every handshake is a pop.
- **Reset** (`rstn` low at a rising edge)
  - Pointers, `idx`, `count` and `overflow` clear to 0.
  - All `mem` entries clear to 0.
  - Hence `out_valid = 0`, `out_data = 0`, `out_index = 0`, `out_last = (N == 1)`, `full = 0`.
  - Reset overrides any simultaneous write or handshake.
  - A vector that is partially sent when reset hits is lost; no resume.

## Timing
- Capture to first output: a vector presented with `in_valid` at edge t into an empty buffer gives `out_valid = 1` with element 0 after edge t, i.e. 1 cycle.
- No combinational path from `in_*` to any output.
- The only combinational path is `out_ready` → internal next-state. No output depends combinationally on `out_ready`.
- Throughput: one element per cycle while `out_ready` is held high. Sustained input must average ≤ 1 vector per N cycles to avoid drops.
- `full` and `count` reflect registered state. A write arriving while `full` is accepted only via the same-cycle pop rule.

## Test plan
1. **Single vector, continuous drain.** Reset, hold `out_ready=1`, pulse `in_valid` once with {0x3C00, 0x4000, 0x4200} (N=3).
   - Next three cycles: `out_data` = 0x3C00/0x4000/0x4200, `out_index` 0/1/2, `out_last` only on the third.
   - `count` 1→0 after the third cycle; `overflow` stays 0.
2. **Backpressure.** Same vector with `out_ready=0` for 5 cycles, then 1.
   - `out_data` holds 0x3C00 with `out_index=0` throughout the stall.
   - Then streams the three elements in order.
3. **Fill and overflow.** DEPTH=4, `out_ready=0`, five vectors with element0 = 1..5 on consecutive cycles.
   - `count` reaches 4 and `full=1`.
   - The fifth vector is dropped and `overflow=1`.
   - Draining yields element0 = 1, 2, 3, 4 only.
4. **Simultaneous write and pop while full.** Full buffer, head at `idx=2`, `out_ready=1`, and `in_valid` with element0 = 9 in the same cycle.
   - Vector accepted, `count` stays 4, `overflow` stays 0.
   - Vector 9 drains last.
5. **Pointer wrap.** 10 vectors spaced 3 cycles apart with continuous drain.
   - All 30 elements come out in order and `overflow=0`.
6. **Reset mid-vector.** Assert `rstn=0` for 1 cycle after element 1 of a vector has been accepted.
   - Next cycle: `out_valid=0`, `count=0`, `out_data=0`, `overflow=0`.
   - A new vector afterwards starts at `out_index=0`.
